dmem_lsu: RTL and testbench

//   Load/store initiator between the MEM pipeline stage and the word-wide data memory
//   (256 x 32-bit, asynchronous read, synchronous word write). Accepts LB/LBU/LH/LHU/LW/SB/SH/SW

---
 rtl/dmem_lsu.sv | 171 +++++++++++++++++
 tb/tb_dmem_lsu.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit between the MEM stage and a word-wide data memory.
// Sub-word stores go through a read-modify-write cycle; misaligned ops complete without access.
module dmem_lsu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned WORD_AW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_misalign,
    output logic            stall,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wd,
    input  logic [XLEN-1:0] dmem_rd
);

    if (WORD_AW + 2 > XLEN) begin : g_bad_word_aw
        $error("WORD_AW does not fit in XLEN");
    end

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e          state_q, state_d;
    logic            we_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] old_q, old_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            misalign_q, misalign_d;

    logic            accept;
    logic            req_misalign;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] merged_wd;

    assign accept = req_valid && (state_q == StIdle);

    assign req_misalign = (req_size == 2'b11)
                        | ((req_size == 2'b01) & req_addr[0])
                        | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));

    // Lane extraction from the word currently on the read port.
    assign ld_byte = dmem_rd[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = dmem_rd[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = dmem_rd;
        case (size_q)
            2'b00: load_ext = uns_q ? {{(XLEN-8){1'b0}}, ld_byte}
                                    : {{(XLEN-8){ld_byte[7]}}, ld_byte};
            2'b01: load_ext = uns_q ? {{(XLEN-16){1'b0}}, ld_half}
                                    : {{(XLEN-16){ld_half[15]}}, ld_half};
            default: load_ext = dmem_rd;
        endcase
    end

    // Store data merged into the word captured during READ; other lanes keep old contents.
    always_comb begin
        merged_wd = old_q;
        case (size_q)
            2'b00: merged_wd[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01: merged_wd[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged_wd = wdata_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        old_d      = old_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_misalign) begin
                        state_d    = StDone;
                        rdata_d    = '0;
                        misalign_d = 1'b1;
                    end else if (!req_we || (req_size != 2'b10)) begin
                        state_d = StRead;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StRead: begin
                if (we_q) begin
                    old_d   = dmem_rd;
                    state_d = StWrite;
                end else begin
                    rdata_d    = load_ext;
                    misalign_d = 1'b0;
                    state_d    = StDone;
                end
            end
            StWrite: begin
                rdata_d    = '0;
                misalign_d = 1'b0;
                state_d    = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            old_q      <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            old_q      <= old_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_comb begin
        req_ready     = (state_q == StIdle);
        resp_valid    = (state_q == StDone);
        resp_rdata    = rdata_q;
        resp_misalign = misalign_q;
        stall         = ((state_q == StIdle) && req_valid)
                      || (state_q == StRead) || (state_q == StWrite);
        dmem_we       = (state_q == StWrite) && !rst;
        dmem_addr     = '0;
        dmem_wd       = '0;
        if ((state_q == StRead) || (state_q == StWrite)) begin
            dmem_addr = {addr_q[XLEN-1:2], 2'b00};
        end
        if (state_q == StWrite) begin
            dmem_wd = merged_wd;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural 256x32 data memory attached.
module tb_dmem_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic        stall;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wd;
    logic [31:0] dmem_rd;

    int n_total;
    int n_bad;

    logic [31:0] mem [256];
    logic        tb_wr_en;
    logic [7:0]  tb_wr_idx;
    logic [31:0] tb_wr_data;

    // Observations of the most recent run_op call.
    int          op_lat;
    int          op_we_cnt;
    int          op_we_cyc;
    logic [31:0] op_we_addr;
    logic [31:0] op_we_data;
    logic [31:0] op_rdata;
    logic        op_mis;
    logic        op_stall_issue;
    logic        op_ready_issue;
    logic        op_stall_mid;
    logic        op_ready_mid;
    logic        op_stall_done;
    logic        op_ready_done;

    dmem_lsu #(
        .XLEN   (32),
        .WORD_AW(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_misalign(resp_misalign),
        .stall        (stall),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wd      (dmem_wd),
        .dmem_rd      (dmem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_wr_en) mem[tb_wr_idx] <= tb_wr_data;
        else if (dmem_we) mem[dmem_addr[9:2]] <= dmem_wd;
    end
    assign dmem_rd = mem[dmem_addr[9:2]];

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        tb_wr_en   = 1'b1;
        tb_wr_idx  = addr[9:2];
        tb_wr_data = data;
        @(negedge clk);
        tb_wr_en = 1'b0;
    endtask

    // Issues one request and records what the DUT does until resp_valid (bounded).
    task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        #1;
        op_stall_issue = stall;
        op_ready_issue = req_ready;
        @(posedge clk);
        #1;
        // Scramble request fields: the DUT must use its latched copy.
        req_valid    = 1'b0;
        req_we       = ~we;
        req_size     = 2'b10;
        req_unsigned = ~uns;
        req_addr     = 32'hFFFF_FFFC;
        req_wdata    = 32'h5A5A_5A5A;
        op_lat    = 99;
        op_we_cnt = 0;
        op_we_cyc = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                op_stall_mid = stall;
                op_ready_mid = req_ready;
            end
            if (dmem_we) begin
                op_we_cnt++;
                op_we_cyc  = c;
                op_we_addr = dmem_addr;
                op_we_data = dmem_wd;
            end
            if (resp_valid) begin
                op_lat        = c;
                op_rdata      = resp_rdata;
                op_mis        = resp_misalign;
                op_stall_done = stall;
                op_ready_done = req_ready;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        n_total++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
        n_total++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
        n_total++; if (dmem_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", dmem_we); end
        n_total++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
    endtask

    task automatic test_word();
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        n_total++; if (op_ready_issue !== 1'b1) begin n_bad++; $display("FAIL sw_ready: got %b want 1", op_ready_issue); end
        n_total++; if (op_stall_issue !== 1'b1) begin n_bad++; $display("FAIL sw_stall_issue: got %b want 1", op_stall_issue); end
        n_total++; if (op_lat !== 2) begin n_bad++; $display("FAIL sw_lat: got %0d want 2", op_lat); end
        n_total++; if (op_we_cnt !== 1) begin n_bad++; $display("FAIL sw_we_cnt: got %0d want 1", op_we_cnt); end
        n_total++; if (op_we_cyc !== 1) begin n_bad++; $display("FAIL sw_we_cyc: got %0d want 1", op_we_cyc); end
        n_total++; if (op_we_addr !== 32'h10) begin n_bad++; $display("FAIL sw_addr: got %h want 00000010", op_we_addr); end
        n_total++; if (op_we_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_wd: got %h want deadbeef", op_we_data); end
        n_total++; if (op_stall_mid !== 1'b1) begin n_bad++; $display("FAIL sw_stall_mid: got %b want 1", op_stall_mid); end
        n_total++; if (op_ready_mid !== 1'b0) begin n_bad++; $display("FAIL sw_ready_mid: got %b want 0", op_ready_mid); end
        n_total++; if (op_stall_done !== 1'b0) begin n_bad++; $display("FAIL sw_stall_done: got %b want 0", op_stall_done); end
        n_total++; if (op_ready_done !== 1'b0) begin n_bad++; $display("FAIL sw_ready_done: got %b want 0", op_ready_done); end
        n_total++; if (op_rdata !== 32'h0) begin n_bad++; $display("FAIL sw_rdata: got %h want 0", op_rdata); end
        n_total++; if (mem[4] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_mem: got %h want deadbeef", mem[4]); end
        run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        n_total++; if (op_lat !== 2) begin n_bad++; $display("FAIL lw_lat: got %0d want 2", op_lat); end
        n_total++; if (op_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_rdata: got %h want deadbeef", op_rdata); end
        n_total++; if (op_we_cnt !== 0) begin n_bad++; $display("FAIL lw_we_cnt: got %0d want 0", op_we_cnt); end
        n_total++; if (op_mis !== 1'b0) begin n_bad++; $display("FAIL lw_mis: got %b want 0", op_mis); end
    endtask

    task automatic test_byte();
        poke(32'h10, 32'h1122_3344);
        run_op(1'b1, 2'b00, 1'b0, 32'h13, 32'h1234_56A5);
        n_total++; if (op_lat !== 3) begin n_bad++; $display("FAIL sb_lat: got %0d want 3", op_lat); end
        n_total++; if (op_we_cnt !== 1) begin n_bad++; $display("FAIL sb_we_cnt: got %0d want 1", op_we_cnt); end
        n_total++; if (op_we_cyc !== 2) begin n_bad++; $display("FAIL sb_we_cyc: got %0d want 2", op_we_cyc); end
        n_total++; if (op_we_addr !== 32'h10) begin n_bad++; $display("FAIL sb_addr: got %h want 00000010", op_we_addr); end
        n_total++; if (op_we_data !== 32'hA522_3344) begin n_bad++; $display("FAIL sb_wd: got %h want a5223344", op_we_data); end
        n_total++; if (op_stall_mid !== 1'b1) begin n_bad++; $display("FAIL sb_stall_mid: got %b want 1", op_stall_mid); end
        run_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        n_total++; if (op_rdata !== 32'hFFFF_FFA5) begin n_bad++; $display("FAIL lb: got %h want ffffffa5", op_rdata); end
        run_op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        n_total++; if (op_rdata !== 32'h0000_00A5) begin n_bad++; $display("FAIL lbu: got %h want 000000a5", op_rdata); end
        run_op(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        n_total++; if (op_rdata !== 32'h0000_0044) begin n_bad++; $display("FAIL lb_lane0: got %h want 00000044", op_rdata); end
        run_op(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        n_total++; if (op_rdata !== 32'h0000_0033) begin n_bad++; $display("FAIL lb_lane1: got %h want 00000033", op_rdata); end
    endtask

    task automatic test_half();
        poke(32'h10, 32'h1122_3344);
        run_op(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_8001);
        n_total++; if (op_lat !== 3) begin n_bad++; $display("FAIL sh_lat: got %0d want 3", op_lat); end
        n_total++; if (op_we_data !== 32'h8001_3344) begin n_bad++; $display("FAIL sh_wd: got %h want 80013344", op_we_data); end
        n_total++; if (mem[4] !== 32'h8001_3344) begin n_bad++; $display("FAIL sh_mem: got %h want 80013344", mem[4]); end
        run_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        n_total++; if (op_rdata !== 32'hFFFF_8001) begin n_bad++; $display("FAIL lh: got %h want ffff8001", op_rdata); end
        run_op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        n_total++; if (op_rdata !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu: got %h want 00008001", op_rdata); end
        run_op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        n_total++; if (op_rdata !== 32'h0000_3344) begin n_bad++; $display("FAIL lh_low: got %h want 00003344", op_rdata); end
    endtask

    task automatic test_misalign();
        logic [1:0]  sizes [3];
        logic        wes   [3];
        logic [31:0] addrs [3];
        sizes[0] = 2'b10; wes[0] = 1'b0; addrs[0] = 32'h0E;
        sizes[1] = 2'b01; wes[1] = 1'b1; addrs[1] = 32'h11;
        sizes[2] = 2'b11; wes[2] = 1'b1; addrs[2] = 32'h10;
        poke(32'h0C, 32'hCAFE_F00D);
        poke(32'h10, 32'h1122_3344);
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
            run_op(wes[i], sizes[i], 1'b0, addrs[i], 32'hFFFF_FFFF);
            n_total++; if (op_lat !== 1) begin n_bad++; $display("FAIL mis%0d_lat: got %0d want 1", i, op_lat); end
            n_total++; if (op_mis !== 1'b1) begin n_bad++; $display("FAIL mis%0d_flag: got %b want 1", i, op_mis); end
            n_total++; if (op_rdata !== 32'h0) begin n_bad++; $display("FAIL mis%0d_rdata: got %h want 0", i, op_rdata); end
            n_total++; if (op_we_cnt !== 0) begin n_bad++; $display("FAIL mis%0d_we: got %0d want 0", i, op_we_cnt); end
        end
        n_total++; if (mem[4] !== 32'h1122_3344) begin n_bad++; $display("FAIL mis_mem4: got %h want 11223344", mem[4]); end
        n_total++; if (mem[3] !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL mis_mem3: got %h want cafef00d", mem[3]); end
        run_op(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
        n_total++; if (op_mis !== 1'b0) begin n_bad++; $display("FAIL mis_clear: got %b want 0", op_mis); end
        n_total++; if (op_rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL mis_after_lw: got %h want cafef00d", op_rdata); end
    endtask

    task automatic test_reset_write();
        int pulses;
        poke(32'h10, 32'h1122_3344);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h13; req_wdata = 32'h0000_00A5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_total++; if (dmem_we !== 1'b1) begin n_bad++; $display("FAIL rw_in_write: got %b want 1", dmem_we); end
        rst = 1'b1;
        #1;
        n_total++; if (dmem_we !== 1'b0) begin n_bad++; $display("FAIL rw_we_rst: got %b want 0", dmem_we); end
        @(negedge clk);
        rst = 1'b0;
        n_total++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rw_idle: got %b want 1", req_ready); end
        pulses = 0;
        if (resp_valid) pulses++;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        n_total++; if (pulses !== 0) begin n_bad++; $display("FAIL rw_resp: got %0d want 0", pulses); end
        n_total++; if (mem[4] !== 32'h1122_3344) begin n_bad++; $display("FAIL rw_mem: got %h want 11223344", mem[4]); end
    endtask

    task automatic test_back_to_back();
        int accepts;
        int ready_low;
        poke(32'h20, 32'h0BAD_F00D);
        // Hold req_valid high across two LWs; a new accept must wait for DONE to pass.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h0;
        accepts = 0;
        ready_low = 0;
        for (int c = 0; c < 6; c++) begin
            if (req_ready) accepts++;
            else ready_low++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_total++; if (accepts !== 2) begin n_bad++; $display("FAIL b2b_accepts: got %0d want 2", accepts); end
        n_total++; if (ready_low !== 4) begin n_bad++; $display("FAIL b2b_busy: got %0d want 4", ready_low); end
        repeat (3) @(negedge clk);
        n_total++; if (resp_rdata !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL b2b_rdata: got %h want 0badf00d", resp_rdata); end
    endtask

    initial begin
        n_total      = 0;
        n_bad        = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        tb_wr_en     = 1'b0;
        tb_wr_idx    = 8'h0;
        tb_wr_data   = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_reset_write();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
